bench_vector_scheduler: RTL

//   Shares one sequential benchmark core (s820-class: 18 primary inputs, 19 outputs, CK-clocked)

---
 rtl/bench_sched_pkg.sv | 17 +
 rtl/bench_vector_scheduler_rr_arbiter.sv | 34 +++
 rtl/bench_vector_scheduler.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bench_sched_pkg.sv
// Shared types and default geometry for the benchmark-core vector scheduler.
// The defaults describe an s820-class core shared by four requesters.
package bench_sched_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_IN_W  = 18;
  localparam int DEF_OUT_W = 19;
  localparam int DEF_CYC_W = 4;
  localparam int ID_W      = $clog2(DEF_NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/bench_vector_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after the pointer,
// wrapping around, and returns the grant both one-hot and encoded.
module rr_arbiter
  import bench_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int PTR_W = ID_W
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] grant_id,
  output logic             grant_valid
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the search loop, so no path
    // through this block leaves a value unassigned and no latch is inferred.
    grant       = '0;
    grant_id    = '0;
    grant_valid = 1'b0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!grant_valid && req[idx]) begin
        grant_valid = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/bench_vector_scheduler.sv
// Shares one sequential benchmark core between NREQ requesters: round-robin grant,
// hold the granted vector for N clocks, capture the core outputs and return them.
module bench_vector_scheduler
  import bench_sched_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int IN_W  = DEF_IN_W,
  parameter  int OUT_W = DEF_OUT_W,
  parameter  int CYC_W = DEF_CYC_W,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  CK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*IN_W-1:0]  req_vec,
  input  logic [NREQ*CYC_W-1:0] req_cyc,
  input  logic [NREQ-1:0]       req_clr,
  output logic [IN_W-1:0]       core_in,
  output logic                  core_clr,
  input  logic [OUT_W-1:0]      core_out,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [OUT_W-1:0]      rsp_data
);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [CYC_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  vec_q, vec_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             clr_q, clr_d;
  logic             first_q, first_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [OUT_W-1:0] rsp_data_q, rsp_data_d;

  logic [NREQ-1:0]  arb_req;
  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   grant_id;
  logic             grant_valid;
  logic [IN_W-1:0]  sel_vec;
  logic [CYC_W-1:0] sel_cyc;
  logic             sel_clr;
  logic [IDW-1:0]   ptr_next;

  // Requests are only visible to the arbiter while idle and out of reset.
  assign arb_req   = (state_q == IDLE && !RST) ? req_valid : '0;
  assign req_ready = grant;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (IDW)
  ) u_arb (
    .req         (arb_req),
    .ptr         (ptr_q),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_vec = '0;
    sel_cyc = '0;
    sel_clr = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_vec = req_vec[i*IN_W +: IN_W];
        sel_cyc = req_cyc[i*CYC_W +: CYC_W];
        sel_clr = req_clr[i];
      end
    end
  end

  assign ptr_next = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    vec_d       = vec_q;
    id_d        = id_q;
    clr_d       = clr_q;
    first_d     = first_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    core_in     = '0;
    core_clr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          vec_d   = sel_vec;
          id_d    = grant_id;
          clr_d   = sel_clr;
          cnt_d   = (sel_cyc == '0) ? CYC_W'(1) : sel_cyc;
          first_d = 1'b1;
          ptr_d   = ptr_next;
          state_d = APPLY;
        end
      end
      APPLY: begin
        core_in  = vec_q;
        core_clr = clr_q & first_q;
        first_d  = 1'b0;
        cnt_d    = cnt_q - CYC_W'(1);
        // Last hold cycle: the core has seen the vector for N clocks.
        if (cnt_q == CYC_W'(1)) begin
          rsp_data_d  = core_out;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      vec_q       <= '0;
      id_q        <= '0;
      clr_q       <= 1'b0;
      first_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      vec_q       <= vec_d;
      id_q        <= id_d;
      clr_q       <= clr_d;
      first_q     <= first_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;

endmodule
